// File: rtl/bmem_axi_writer.sv
// Buffers bmem single-word write requests and replays each one as a single-beat
// AXI4 write, pulsing bmem_resp back to the requester when the B response lands.
module bmem_axi_writer #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bmem_wr_en,
  input  logic [31:0] bmem_wr_addr,
  input  logic [63:0] bmem_wr_data,
  output logic        bmem_resp,
  output logic        bmem_overflow,
  output logic        bmem_wr_err,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  output logic [63:0] wdata,
  output logic [7:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_B,
    S_RESP
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [95:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W:0]    r_wptr;
  logic [PTR_W:0]    r_rptr;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic [95:0]       w_head;
  logic              r_awvalid;
  logic              r_wvalid;
  logic [31:0]       r_awaddr;
  logic [63:0]       r_wdata;
  logic [1:0]        r_bresp;
  logic              r_overflow;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                   (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
  assign w_head  = r_mem[r_rptr[PTR_W-1:0]];
  assign w_push  = bmem_wr_en && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[PTR_W-1:0]] <= {bmem_wr_addr, bmem_wr_data};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        // AW and W retire independently; leave only once both are done.
        if ((!r_awvalid || awready) && (!r_wvalid || wready)) begin
          w_state_nxt = S_WAIT_B;
        end
      end
      S_WAIT_B: begin
        if (bvalid) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_awvalid  <= 1'b0;
      r_wvalid   <= 1'b0;
      r_awaddr   <= '0;
      r_wdata    <= '0;
      r_bresp    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      if (bmem_wr_en && !w_push) begin
        r_overflow <= 1'b1;
      end
      if (w_pop) begin
        r_awvalid <= 1'b1;
        r_wvalid  <= 1'b1;
        r_awaddr  <= {w_head[95:67], 3'b000};
        r_wdata   <= w_head[63:0];
      end else begin
        if (awready) begin
          r_awvalid <= 1'b0;
        end
        if (wready) begin
          r_wvalid <= 1'b0;
        end
      end
      if (bvalid && bready) begin
        r_bresp <= bresp;
      end
    end
  end

  assign awaddr        = r_awaddr;
  assign awlen         = 8'd0;
  assign awsize        = 3'b011;
  assign awburst       = 2'b01;
  assign awvalid       = r_awvalid;
  assign wdata         = r_wdata;
  assign wstrb         = 8'hFF;
  assign wlast         = 1'b1;
  assign wvalid        = r_wvalid;
  assign bready        = (r_state == S_WAIT_B);
  assign bmem_resp     = (r_state == S_RESP);
  assign bmem_wr_err   = (r_state == S_RESP) && (r_bresp != 2'b00);
  assign bmem_overflow = r_overflow;

endmodule
